// File: rtl/pic_pkg.sv
// Shared PIC definitions: IR count, level width, acknowledge FSM states, rank helper.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package pic_pkg;

  localparam int IR_COUNT = 8;
  localparam int LVL_W    = 3;

  typedef logic [LVL_W-1:0]    level_t;
  typedef logic [IR_COUNT-1:0] ir_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } seq_state_t;

  // Rank 0 is the highest priority, sitting one above the current lowest level.
  function automatic level_t pri_rank(input level_t lvl, input level_t lowest);
    return lvl - lowest - 3'd1;
  endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// Request/EOI/acknowledge inputs and ISR/vector outputs of the INTA sequencer.
// Latency: none (wiring only).
// Backpressure: none; the CPU paces the sequence through inta_n edges.
interface inta_sequencer_if;
  import pic_pkg::*;

  ir_vec_t      irq_req;
  logic [4:0]   vector_base;
  logic         auto_eoi;
  logic         rotate_en;
  logic         eoi_cmd;
  logic         eoi_specific;
  level_t       eoi_level;
  logic         inta_n;

  logic         int_out;
  ir_vec_t      isr;
  ir_vec_t      irq_clear;
  logic [7:0]   data_out;
  logic         data_oe;
  level_t       lowest_pri;

  modport master (
    output irq_req, vector_base, auto_eoi, rotate_en,
           eoi_cmd, eoi_specific, eoi_level, inta_n,
    input  int_out, isr, irq_clear, data_out, data_oe, lowest_pri
  );

  modport slave (
    input  irq_req, vector_base, auto_eoi, rotate_en,
           eoi_cmd, eoi_specific, eoi_level, inta_n,
    output int_out, isr, irq_clear, data_out, data_oe, lowest_pri
  );

endinterface

// File: rtl/rot_priority_encoder.sv
// Circular find-first: highest-ranked set bit, ranking starts at base+1 and wraps upward.
// Latency: combinational.
// Backpressure: not applicable.
module rot_priority_encoder
  import pic_pkg::*;
(
  input  ir_vec_t request,
  input  level_t  base,
  output logic    valid,
  output level_t  level
);

  level_t idx;

  // Scan from lowest rank to highest so the last hit written is the winner.
  always_comb begin
    valid = 1'b0;
    level = '0;
    idx   = '0;
    for (int i = IR_COUNT; i >= 1; i--) begin
      idx = base + level_t'(i);
      if (request[idx]) begin
        valid = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// 8259-style INTA sequencer: picks the winning IR, tracks in-service bits, drives the vector.
// Latency: irq_req to int_out 1 cycle; vector valid the cycle after the second INTA fall.
// Backpressure: none; requests wait in irq_req until eligible and acknowledged.
module inta_sequencer
  import pic_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  inta_sequencer_if.slave bus
);

  seq_state_t state;
  logic       inta_q;
  logic       spurious;
  level_t     winner;

  logic       fall;
  logic       rise;
  logic       eligible;
  logic       req_vld;
  logic       isr_vld;
  level_t     req_lvl;
  level_t     isr_lvl;
  logic       eoi_hit;
  level_t     eoi_lvl;
  logic       aeoi_clr;
  ir_vec_t    set_mask;
  ir_vec_t    clr_mask;

  rot_priority_encoder u_req_enc (
    .request (bus.irq_req),
    .base    (bus.lowest_pri),
    .valid   (req_vld),
    .level   (req_lvl)
  );

  rot_priority_encoder u_isr_enc (
    .request (bus.isr),
    .base    (bus.lowest_pri),
    .valid   (isr_vld),
    .level   (isr_lvl)
  );

  assign fall = inta_q & ~bus.inta_n;
  assign rise = ~inta_q & bus.inta_n;

  // A request may interrupt only if it outranks everything already in service.
  assign eligible = req_vld &
                    (~isr_vld | (pri_rank(req_lvl, bus.lowest_pri) < pri_rank(isr_lvl, bus.lowest_pri)));

  assign aeoi_clr = (state == ACK2) & rise & bus.auto_eoi & ~spurious;

  // Resolve which in-service bit an EOI command really clears (none if it is already clear).
  always_comb begin
    eoi_hit = 1'b0;
    eoi_lvl = '0;
    if (bus.eoi_cmd) begin
      if (bus.eoi_specific) begin
        eoi_lvl = bus.eoi_level;
        eoi_hit = bus.isr[bus.eoi_level];
      end else begin
        eoi_lvl = isr_lvl;
        eoi_hit = isr_vld;
      end
    end
  end

  // ISR edits for this cycle; the set is OR-ed in last so it beats a same-bit clear.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if ((state == IDLE) && fall && eligible) set_mask[req_lvl] = 1'b1;
    if (aeoi_clr)                             clr_mask[winner]  = 1'b1;
    if (eoi_hit)                              clr_mask[eoi_lvl] = 1'b1;
  end

  // Acknowledge FSM with all outputs registered; an explicit EOI rotation beats an auto-EOI one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      inta_q         <= 1'b1;
      winner         <= '0;
      spurious       <= 1'b0;
      bus.isr        <= '0;
      bus.lowest_pri <= 3'd7;
      bus.int_out    <= 1'b0;
      bus.irq_clear  <= '0;
      bus.data_oe    <= 1'b0;
      bus.data_out   <= '0;
    end else begin
      inta_q        <= bus.inta_n;
      bus.irq_clear <= '0;
      bus.int_out   <= 1'b0;
      bus.isr       <= (bus.isr & ~clr_mask) | set_mask;

      if (bus.rotate_en) begin
        if (eoi_hit)       bus.lowest_pri <= eoi_lvl;
        else if (aeoi_clr) bus.lowest_pri <= winner;
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state <= ACK1;
            if (eligible) begin
              winner        <= req_lvl;
              spurious      <= 1'b0;
              bus.irq_clear <= set_mask;
            end else begin
              winner   <= 3'd7;
              spurious <= 1'b1;
            end
          end else begin
            bus.int_out <= eligible;
          end
        end
        ACK1: begin
          if (rise) state <= GAP;
        end
        GAP: begin
          if (fall) begin
            state        <= ACK2;
            bus.data_oe  <= 1'b1;
            bus.data_out <= {bus.vector_base, winner};
          end
        end
        ACK2: begin
          if (rise) begin
            state       <= IDLE;
            bus.data_oe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed vector table, hand sequences, randomized run vs. edge-count model.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: none.
module tb_inta_sequencer;
  import pic_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inta_sequencer_if ifc ();

  inta_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [7:0] irq;
    logic       rot;
    logic       eoi;
    logic       eoi_sp;
    logic [2:0] eoi_lvl;
    logic       inta_n;
    logic       exp_int;
    logic [7:0] exp_isr;
    logic [7:0] exp_clr;
    logic [7:0] exp_dout;
    logic       exp_oe;
    logic [2:0] exp_lp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic [7:0] irq, input logic rot,
                             input logic eoi, input logic sp, input logic [2:0] lvl,
                             input logic inta_n, input logic e_int, input logic [7:0] e_isr,
                             input logic [7:0] e_clr, input logic [7:0] e_dout,
                             input logic e_oe, input logic [2:0] e_lp);
    vec_t r;
    r.rst = rst; r.irq = irq; r.rot = rot; r.eoi = eoi; r.eoi_sp = sp; r.eoi_lvl = lvl;
    r.inta_n = inta_n; r.exp_int = e_int; r.exp_isr = e_isr; r.exp_clr = e_clr;
    r.exp_dout = e_dout; r.exp_oe = e_oe; r.exp_lp = e_lp;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the acknowledge is tracked as a count of INTA edges seen (0..3).
  logic [7:0] m_isr, m_clr, m_dout;
  logic [2:0] m_lp, m_winner;
  logic       m_inta_q, m_spur, m_int, m_oe;
  int         m_edges;

  task automatic model_step();
    int best_r, top_r, best, top, k, set_bit;
    logic fall, rise, elig;
    logic [7:0] nxt;
    logic [2:0] nlp;
    if (reset) begin
      m_isr = 0; m_clr = 0; m_dout = 0; m_lp = 3'd7; m_winner = 0;
      m_inta_q = 1; m_spur = 0; m_int = 0; m_oe = 0; m_edges = 0;
      return;
    end
    fall = m_inta_q && !ifc.inta_n;
    rise = !m_inta_q && ifc.inta_n;
    best_r = 8; top_r = 8;
    for (int r = 0; r < 8; r++) begin
      int lvl;
      lvl = (int'(m_lp) + 1 + r) % 8;
      if (best_r == 8 && ifc.irq_req[lvl]) best_r = r;
      if (top_r == 8 && m_isr[lvl]) top_r = r;
    end
    elig = best_r < top_r;
    best = (int'(m_lp) + 1 + best_r) % 8;
    top  = (int'(m_lp) + 1 + top_r) % 8;
    nxt = m_isr; nlp = m_lp; m_clr = 0; m_int = 0; set_bit = -1;
    case (m_edges)
      0: if (fall) begin
           m_edges = 1;
           if (elig) begin
             m_winner = 3'(best); m_spur = 0; set_bit = best; m_clr[best] = 1'b1;
           end else begin
             m_winner = 3'd7; m_spur = 1;
           end
         end else m_int = elig;
      1: if (rise) m_edges = 2;
      2: if (fall) begin
           m_edges = 3; m_oe = 1; m_dout = {ifc.vector_base, m_winner};
         end
      default: if (rise) begin
           m_edges = 0; m_oe = 0;
           if (ifc.auto_eoi && !m_spur) begin
             nxt[m_winner] = 1'b0;
             if (ifc.rotate_en) nlp = m_winner;
           end
         end
    endcase
    if (ifc.eoi_cmd) begin
      k = ifc.eoi_specific ? int'(ifc.eoi_level) : ((top_r < 8) ? top : -1);
      if (k >= 0 && m_isr[k]) begin
        nxt[k] = 1'b0;
        if (ifc.rotate_en) nlp = 3'(k);
      end
    end
    if (set_bit >= 0) nxt[set_bit] = 1'b1;
    m_isr = nxt; m_lp = nlp; m_inta_q = ifc.inta_n;
  endtask

  initial begin
    reset = 1'b1;
    ifc.irq_req = 0; ifc.vector_base = 5'b01000; ifc.auto_eoi = 0; ifc.rotate_en = 0;
    ifc.eoi_cmd = 0; ifc.eoi_specific = 0; ifc.eoi_level = 0; ifc.inta_n = 1;

    //        rst irq   rot eoi sp lvl inta | int isr   clr   dout  oe lp
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 0, 1,  0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 0, 1,  0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(v(0, 8'h24, 0, 0, 0, 0, 1,  1, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(v(0, 8'h24, 0, 0, 0, 0, 0,  0, 8'h04, 8'h04, 8'h00, 0, 7));
    tbl.push_back(v(0, 8'h24, 0, 0, 0, 0, 0,  0, 8'h04, 8'h00, 8'h00, 0, 7));
    tbl.push_back(v(0, 8'h24, 0, 0, 0, 0, 1,  0, 8'h04, 8'h00, 8'h00, 0, 7));
    tbl.push_back(v(0, 8'h24, 0, 0, 0, 0, 0,  0, 8'h04, 8'h00, 8'h42, 1, 7));
    tbl.push_back(v(0, 8'h24, 0, 0, 0, 0, 1,  0, 8'h04, 8'h00, 8'h42, 0, 7));
    tbl.push_back(v(0, 8'h80, 0, 0, 0, 0, 1,  0, 8'h04, 8'h00, 8'h42, 0, 7));
    tbl.push_back(v(0, 8'h80, 0, 0, 0, 0, 1,  0, 8'h04, 8'h00, 8'h42, 0, 7));
    tbl.push_back(v(0, 8'h01, 0, 0, 0, 0, 1,  1, 8'h04, 8'h00, 8'h42, 0, 7));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 1,  0, 8'h04, 8'h00, 8'h42, 0, 7));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 0,  0, 8'h04, 8'h00, 8'h42, 0, 7));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 1,  0, 8'h04, 8'h00, 8'h42, 0, 7));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 0,  0, 8'h04, 8'h00, 8'h47, 1, 7));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 1,  0, 8'h04, 8'h00, 8'h47, 0, 7));
    tbl.push_back(v(0, 8'h00, 0, 1, 1, 2, 1,  0, 8'h00, 8'h00, 8'h47, 0, 7));
    tbl.push_back(v(0, 8'h08, 0, 0, 0, 0, 1,  1, 8'h00, 8'h00, 8'h47, 0, 7));
    tbl.push_back(v(0, 8'h08, 0, 0, 0, 0, 0,  0, 8'h08, 8'h08, 8'h47, 0, 7));
    tbl.push_back(v(0, 8'h08, 0, 0, 0, 0, 1,  0, 8'h08, 8'h00, 8'h47, 0, 7));
    tbl.push_back(v(0, 8'h08, 0, 0, 0, 0, 0,  0, 8'h08, 8'h00, 8'h43, 1, 7));
    tbl.push_back(v(0, 8'h08, 0, 0, 0, 0, 1,  0, 8'h08, 8'h00, 8'h43, 0, 7));
    tbl.push_back(v(0, 8'h00, 1, 1, 0, 0, 1,  0, 8'h00, 8'h00, 8'h43, 0, 3));
    tbl.push_back(v(0, 8'h11, 1, 0, 0, 0, 1,  1, 8'h00, 8'h00, 8'h43, 0, 3));
    tbl.push_back(v(0, 8'h11, 1, 0, 0, 0, 0,  0, 8'h10, 8'h10, 8'h43, 0, 3));
    tbl.push_back(v(0, 8'h11, 1, 0, 0, 0, 1,  0, 8'h10, 8'h00, 8'h43, 0, 3));
    tbl.push_back(v(0, 8'h11, 1, 0, 0, 0, 0,  0, 8'h10, 8'h00, 8'h44, 1, 3));
    tbl.push_back(v(0, 8'h11, 1, 0, 0, 0, 1,  0, 8'h10, 8'h00, 8'h44, 0, 3));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; ifc.irq_req = tbl[i].irq; ifc.rotate_en = tbl[i].rot;
      ifc.eoi_cmd = tbl[i].eoi; ifc.eoi_specific = tbl[i].eoi_sp;
      ifc.eoi_level = tbl[i].eoi_lvl; ifc.inta_n = tbl[i].inta_n;
      step();
      chk($sformatf("row%0d int_out", i),    32'(ifc.int_out),    32'(tbl[i].exp_int));
      chk($sformatf("row%0d isr", i),        32'(ifc.isr),        32'(tbl[i].exp_isr));
      chk($sformatf("row%0d irq_clear", i),  32'(ifc.irq_clear),  32'(tbl[i].exp_clr));
      chk($sformatf("row%0d data_out", i),   32'(ifc.data_out),   32'(tbl[i].exp_dout));
      chk($sformatf("row%0d data_oe", i),    32'(ifc.data_oe),    32'(tbl[i].exp_oe));
      chk($sformatf("row%0d lowest_pri", i), 32'(ifc.lowest_pri), 32'(tbl[i].exp_lp));
    end

    // Auto-EOI: clear IR4 first, then acknowledge IR2 and expect it gone after the second rise.
    ifc.rotate_en = 0; ifc.eoi_cmd = 1; ifc.eoi_specific = 1; ifc.eoi_level = 3'd4;
    ifc.irq_req = 8'h00; ifc.inta_n = 1;
    step();
    chk("aeoi pre isr", 32'(ifc.isr), 32'h00);
    chk("aeoi pre lp", 32'(ifc.lowest_pri), 32'd3);
    ifc.eoi_cmd = 0; ifc.auto_eoi = 1; ifc.irq_req = 8'h04;
    step();
    chk("aeoi int_out", 32'(ifc.int_out), 32'd1);
    ifc.inta_n = 0; step();
    chk("aeoi set isr", 32'(ifc.isr), 32'h04);
    chk("aeoi irq_clear", 32'(ifc.irq_clear), 32'h04);
    ifc.inta_n = 1; step();
    ifc.inta_n = 0; step();
    chk("aeoi vector", 32'({ifc.data_oe, ifc.data_out}), 32'h142);
    chk("aeoi isr held", 32'(ifc.isr), 32'h04);
    ifc.irq_req = 8'h00; ifc.inta_n = 1; step();
    chk("aeoi isr cleared", 32'(ifc.isr), 32'h00);
    chk("aeoi oe off", 32'(ifc.data_oe), 32'd0);

    // Reset while in GAP, with the second INTA fall arriving in the same cycle.
    ifc.auto_eoi = 0; ifc.irq_req = 8'h01;
    step();
    ifc.inta_n = 0; step();
    chk("rstgap isr set", 32'(ifc.isr), 32'h01);
    ifc.inta_n = 1; step();
    reset = 1; ifc.inta_n = 0; step();
    chk("rstgap isr", 32'(ifc.isr), 32'h00);
    chk("rstgap oe", 32'(ifc.data_oe), 32'd0);
    chk("rstgap lp", 32'(ifc.lowest_pri), 32'd7);
    chk("rstgap int", 32'(ifc.int_out), 32'd0);
    reset = 0; ifc.inta_n = 1; step();
    chk("rstgap idle oe", 32'(ifc.data_oe), 32'd0);
    chk("rstgap idle int", 32'(ifc.int_out), 32'd1);

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      reset = (c == 0) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) ifc.irq_req = 8'($urandom & $urandom);
      if ($urandom_range(0, 199) == 0) ifc.vector_base = 5'($urandom);
      if (c % 64 == 0) begin
        ifc.auto_eoi  = 1'($urandom);
        ifc.rotate_en = 1'($urandom);
      end
      ifc.eoi_cmd      = ($urandom_range(0, 9) == 0);
      ifc.eoi_specific = 1'($urandom);
      ifc.eoi_level    = 3'($urandom);
      if ($urandom_range(0, 2) == 0) ifc.inta_n = ~ifc.inta_n;
      model_step();
      step();
      chk($sformatf("rand cycle %0d", c),
          32'({ifc.int_out, ifc.isr, ifc.irq_clear, ifc.data_out, ifc.data_oe, ifc.lowest_pri}),
          32'({m_int, m_isr, m_clr, m_dout, m_oe, m_lp}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: irq_req  in  8  masked requests from the IRR block, bit n = IRn.
REQ-004 SHALL have: vector_base  in  5  ICW2 T7..T3.
REQ-005 SHALL have: auto_eoi  in  1  auto-EOI mode enable.
REQ-006 SHALL have: rotate_en  in  1  rotate-on-EOI enable.
REQ-007 SHALL have: eoi_cmd  in  1  one-cycle EOI strobe.
REQ-008 SHALL have: eoi_specific  in  1  1 = specific EOI, 0 = non-specific.
REQ-009 SHALL have: eoi_level  in  3  level for specific EOI.
REQ-010 SHALL have: inta_n  in  1  CPU acknowledge, active-low, synchronous to clk.
REQ-011 SHALL have: int_out  out  1  interrupt request to CPU.
REQ-012 SHALL have: isr  out  8  in-service register.
REQ-013 SHALL have: irq_clear  out  8  one-cycle pulse clearing the edge latch of the acknowledged IR.
REQ-014 SHALL have: data_out  out  8  vector byte; data_oe  out  1  vector drive enable.
REQ-015 SHALL have: lowest_pri  out  3  current lowest-priority level.

Function
REQ-016 SHALL register inta_n into inta_q; fall = inta_q & ~inta_n, rise = ~inta_q & inta_n.
REQ-017 SHALL rank priority circularly: highest = (lowest_pri+1) mod 8, ascending with wrap.
REQ-018 SHALL define eligible = any irq_req bit ranked strictly above the highest set isr bit; all requests are eligible when isr = 0.
REQ-019 SHALL use the FSM states IDLE, ACK1, GAP and ACK2.
REQ-020 SHALL, in IDLE, register int_out = eligible, giving 1 cycle latency from irq_req to int_out.
REQ-021 SHALL, on IDLE fall, latch winner = highest-ranked eligible request, set isr[winner], pulse irq_clear[winner] for 1 cycle, and go to ACK1.
REQ-022 SHALL, on IDLE fall with no eligible request, latch winner = 7 (spurious), leave isr and irq_clear unchanged, and go to ACK1.
REQ-023 SHALL hold int_out = 0 in ACK1, GAP and ACK2.
REQ-024 SHALL transition ACK1 -> GAP on rise.
REQ-025 SHALL transition GAP -> ACK2 on fall, asserting data_oe = 1 and data_out = {vector_base, winner} from the next cycle until leaving ACK2.
REQ-026 SHALL, on ACK2 rise, go to IDLE with data_oe = 0; if auto_eoi and not spurious, clear isr[winner], and additionally set lowest_pri = winner if rotate_en.
REQ-027 SHALL accept eoi_cmd in any state: specific clears isr[eoi_level]; non-specific clears the highest-ranked set isr bit and is a no-op if isr = 0.
REQ-028 SHALL, when rotate_en and an EOI actually clears bit k, set lowest_pri = k in the same cycle.
REQ-029 SHALL compute EOI from pre-update isr; when an EOI clear and an ACK1 set hit the same bit in one cycle, the set SHALL win.
REQ-030 SHALL ignore irq_req changes after the winner is latched until return to IDLE.

Reset
REQ-031 SHALL, on reset, force state = IDLE, isr = 0, lowest_pri = 7, int_out = 0, irq_clear = 0, data_oe = 0, data_out = 0, inta_q = 1, winner = 0.
REQ-032 SHALL abort any acknowledge cycle when reset is asserted mid-sequence, with no vector driven on the following cycle.

Structure
REQ-033 SHALL place the FSM state enum, IR count 8 and level width 3 in shared package pic_pkg.
REQ-034 SHALL implement the circular find-first as sub-module rot_priority_encoder (request 8, base 3 -> valid, level 3), instantiated for requests and for isr.

Verification
REQ-035 SHALL cover: vector_base = 5'b01000, irq_req = 8'h24, INTA pair -> isr = 8'h04, irq_clear = 8'h04 pulse, data_out = 8'h42.
REQ-036 SHALL cover: isr = 8'h04 then irq_req = 8'h80 -> int_out stays 0; then irq_req = 8'h01 -> int_out = 1 after 1 cycle.
REQ-037 SHALL cover: INTA pair with irq_req = 0 -> data_out = {base,3'd7}, isr unchanged.
REQ-038 SHALL cover: rotate_en = 1, isr = 8'h08, non-specific EOI -> isr = 0, lowest_pri = 3; next irq_req = 8'h11 -> IR4 chosen.
REQ-039 SHALL cover: auto_eoi = 1, IR2 acknowledged -> isr = 0 after second INTA rise.
REQ-040 SHALL cover: reset asserted in GAP -> next cycle state IDLE, isr = 0, data_oe = 0, lowest_pri = 7.
